// File: rtl/mac_tile_array_acc.sv
// Multi-tile MAC array: N_OUT adder trees, group accumulator, bias/skip/ReLU, saturation.
// Define MAC_TILE_ROUND_EN for round-half-up on the final FRAC shift.
module mac_tile_array_acc #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 16,
  parameter int DW    = 16,
  parameter int BW    = 18,
  parameter int FRAC  = 8,
  parameter int ACCW  = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [N_IN*DW-1:0]         act_in,
  input  logic [N_OUT*N_IN*DW-1:0]   weight_in,
  input  logic [N_OUT*BW-1:0]        bias_in,
  input  logic [N_OUT*DW-1:0]        skip_in,
  input  logic                       skip_en,
  input  logic                       relu_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT*DW-1:0]        out_data,
  output logic                       sat_flag
);

  localparam int PW = 2 * DW;

`ifdef MAC_TILE_ROUND_EN
  localparam logic signed [ACCW-1:0] RND =
    {{(ACCW-1){1'b0}}, 1'b1} << (FRAC - 1);
`else
  localparam logic signed [ACCW-1:0] RND = '0;
`endif

  localparam logic signed [ACCW:0] MAXV =
    {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV =
    {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};

  logic w_adv;
  logic r_out_valid;
  logic [N_OUT*DW-1:0] r_out_data;
  logic r_sat;

  assign w_adv     = !(r_out_valid && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_flag  = r_sat;

  // S1: products plus group context
  logic signed [PW-1:0] w_prod [N_OUT][N_IN];
  logic signed [PW-1:0] r1_prod [N_OUT][N_IN];
  logic r1_valid, r1_last, r1_first, r_first;
  logic r1_skip_en, r1_relu_en;
  logic [N_OUT*BW-1:0] r1_bias;
  logic [N_OUT*DW-1:0] r1_skip;

  always_comb begin
    for (int c = 0; c < N_OUT; c++) begin
      for (int i = 0; i < N_IN; i++) begin
        w_prod[c][i] =
          $signed({{DW{act_in[i*DW+DW-1]}}, act_in[i*DW +: DW]}) *
          $signed({{DW{weight_in[(c*N_IN+i)*DW+DW-1]}},
                   weight_in[(c*N_IN+i)*DW +: DW]});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r_first  <= 1'b1;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_prod    <= w_prod;
        r1_last    <= in_last;
        r1_first   <= r_first;
        r_first    <= in_last;
        r1_bias    <= bias_in;
        r1_skip    <= skip_in;
        r1_skip_en <= skip_en;
        r1_relu_en <= relu_en;
      end
    end
  end

  // S2: per-channel tree sums
  logic signed [ACCW-1:0] w_sum [N_OUT];
  logic signed [ACCW-1:0] r2_sum [N_OUT];
  logic r2_valid, r2_last, r2_first;
  logic r2_skip_en, r2_relu_en;
  logic [N_OUT*BW-1:0] r2_bias;
  logic [N_OUT*DW-1:0] r2_skip;

  always_comb begin
    for (int c = 0; c < N_OUT; c++) begin
      w_sum[c] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_sum[c] = w_sum[c] +
          {{(ACCW-PW){r1_prod[c][i][PW-1]}}, r1_prod[c][i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sum     <= w_sum;
        r2_last    <= r1_last;
        r2_first   <= r1_first;
        r2_bias    <= r1_bias;
        r2_skip    <= r1_skip;
        r2_skip_en <= r1_skip_en;
        r2_relu_en <= r1_relu_en;
      end
    end
  end

  // S3: accumulate, wrapping modulo 2^ACCW
  logic signed [ACCW-1:0] w_acc_nxt [N_OUT];
  logic signed [ACCW-1:0] r_acc [N_OUT];
  logic r3_valid, r3_skip_en, r3_relu_en;
  logic [N_OUT*DW-1:0] r3_skip;

  always_comb begin
    for (int c = 0; c < N_OUT; c++) begin
      if (r2_first)
        w_acc_nxt[c] = r2_sum[c] +
          ({{(ACCW-BW){r2_bias[c*BW+BW-1]}}, r2_bias[c*BW +: BW]}
           << FRAC);
      else
        w_acc_nxt[c] = r_acc[c] + r2_sum[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_valid <= 1'b0;
      for (int c = 0; c < N_OUT; c++) r_acc[c] <= '0;
    end else if (w_adv) begin
      r3_valid <= r2_valid && r2_last;
      if (r2_valid) r_acc <= w_acc_nxt;
      if (r2_valid && r2_last) begin
        r3_skip    <= r2_skip;
        r3_skip_en <= r2_skip_en;
        r3_relu_en <= r2_relu_en;
      end
    end
  end

  // Finalise: shift, skip, ReLU, clamp
  logic [DW-1:0] w_res [N_OUT];
  logic w_clamp [N_OUT];
  logic w_sat;

  always_comb begin
    logic signed [ACCW-1:0] t;
    logic signed [ACCW:0] v;
    w_sat = 1'b0;
    for (int c = 0; c < N_OUT; c++) begin
      t = (r_acc[c] + RND) >>> FRAC;
      v = {t[ACCW-1], t};
      if (r3_skip_en)
        v = v + {{(ACCW+1-DW){r3_skip[c*DW+DW-1]}},
                 r3_skip[c*DW +: DW]};
      if (r3_relu_en && v[ACCW]) v = '0;
      w_clamp[c] = 1'b0;
      w_res[c]   = v[DW-1:0];
      if (v > MAXV) begin
        w_res[c]   = MAXV[DW-1:0];
        w_clamp[c] = 1'b1;
      end else if (v < MINV) begin
        w_res[c]   = MINV[DW-1:0];
        w_clamp[c] = 1'b1;
      end
      w_sat = w_sat | w_clamp[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r3_valid;
      if (r3_valid) begin
        for (int c = 0; c < N_OUT; c++)
          r_out_data[c*DW +: DW] <= w_res[c];
        r_sat <= w_sat;
      end
    end
  end

endmodule
